// File: rtl/mem_access_unit.sv
// Pipeline MEM-stage bridge to a single-outstanding memory bus with lane steering,
// load sign extension, misalignment trapping and an ack timeout.
module mem_access_unit (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_Datatype,
    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] MEM_Data2,
    input  logic [31:0] Bus_RData,
    input  logic        Bus_Ack,
    output logic        Bus_Req,
    output logic        Bus_We,
    output logic [31:0] Bus_Addr,
    output logic [31:0] Bus_WData,
    output logic [3:0]  Bus_BE,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Misaligned,
    output logic        BusErr
);

    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        access_s;
    logic        misal_s;
    logic        start_s;
    logic        misal_evt_s;
    logic        ack_evt_s;
    logic        tmo_evt_s;
    logic        is_load_r;
    logic [1:0]  dtype_r;
    logic [1:0]  lane_r;
    logic [7:0]  tmo_cnt_r;

    function automatic logic is_misaligned(input logic [1:0] dt, input logic [1:0] a);
        logic m;
        case (dt)
            DT_HALF: m = a[0];
            DT_BYTE: m = 1'b0;
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] dt, input logic [1:0] a);
        logic [3:0] be;
        case (dt)
            DT_BYTE: be = 4'b0001 << a;
            DT_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] dt, input logic [31:0] d);
        logic [31:0] w;
        case (dt)
            DT_BYTE: w = {4{d[7:0]}};
            DT_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] dt, input logic [1:0] lane,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{lane, 3'b000} +: 8];
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (dt)
            DT_BYTE: r = {{24{b[7]}}, b};
            DT_HALF: r = {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // State register.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, pipeline stall and datapath event strobes.
    always_comb begin
        state_nxt_s = state_r;
        Stall       = 1'b0;
        start_s     = 1'b0;
        misal_evt_s = 1'b0;
        ack_evt_s   = 1'b0;
        tmo_evt_s   = 1'b0;
        access_s    = MEM_MemWrite | MEM_MemRead;
        misal_s     = is_misaligned(MEM_Datatype, MEM_ALUResult[1:0]);
        case (state_r)
            IDLE: begin
                if (access_s && misal_s) begin
                    misal_evt_s = 1'b1;
                end else if (access_s) begin
                    Stall       = 1'b1;
                    start_s     = 1'b1;
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                Stall = 1'b1;
                // Ack is tested first so a coincident ack beats the timeout.
                if (Bus_Ack) begin
                    ack_evt_s   = 1'b1;
                    state_nxt_s = DONE;
                end else if (tmo_cnt_r == 8'd255) begin
                    tmo_evt_s   = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bus request registers, load result, error pulses and timeout counter.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            Bus_Req    <= 1'b0;
            Bus_We     <= 1'b0;
            Bus_Addr   <= 32'd0;
            Bus_WData  <= 32'd0;
            Bus_BE     <= 4'd0;
            ReadData   <= 32'd0;
            Misaligned <= 1'b0;
            BusErr     <= 1'b0;
            is_load_r  <= 1'b0;
            dtype_r    <= 2'b00;
            lane_r     <= 2'b00;
            tmo_cnt_r  <= 8'd0;
        end else begin
            Misaligned <= misal_evt_s;
            BusErr     <= tmo_evt_s;
            if (start_s) begin
                Bus_Req   <= 1'b1;
                Bus_We    <= MEM_MemWrite;
                Bus_Addr  <= {MEM_ALUResult[31:2], 2'b00};
                Bus_WData <= lane_wdata(MEM_Datatype, MEM_Data2);
                Bus_BE    <= lane_be(MEM_Datatype, MEM_ALUResult[1:0]);
                is_load_r <= ~MEM_MemWrite;
                dtype_r   <= MEM_Datatype;
                lane_r    <= MEM_ALUResult[1:0];
                tmo_cnt_r <= 8'd0;
            end else if (ack_evt_s) begin
                Bus_Req <= 1'b0;
                if (is_load_r) begin
                    ReadData <= load_extend(dtype_r, lane_r, Bus_RData);
                end else begin
                    ReadData <= ReadData;
                end
            end else if (tmo_evt_s) begin
                Bus_Req  <= 1'b0;
                ReadData <= 32'd0;
            end else if (state_r == WAIT) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
        end
    end

endmodule
